// File: rtl/fight_arena_core.sv
// fight_arena_core: two-player fight engine. Positions, health, regen,
// punch/kick resolution and a best-of-N round/match FSM. All game state
// advances only on the internal game tick.
module fight_arena_core #(
    parameter int TICK_DIV    = 20000000,
    parameter int ARENA_LEN   = 4,
    parameter int POS_W       = 2,
    parameter int HP_MAX      = 7,
    parameter int HP_W        = 3,
    parameter int KICK_RANGE  = 1,
    parameter int REGEN_TICKS = 2,
    parameter int ROUND_WIN   = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             p1_kick,
    input  logic             p1_punch,
    input  logic             p1_wait,
    input  logic             p1_jump,
    input  logic             p1_fwd,
    input  logic             p1_back,
    input  logic             p2_kick,
    input  logic             p2_punch,
    input  logic             p2_wait,
    input  logic             p2_jump,
    input  logic             p2_fwd,
    input  logic             p2_back,
    output logic [POS_W-1:0] p1_pos,
    output logic [POS_W-1:0] p2_pos,
    output logic [HP_W-1:0]  p1_health,
    output logic [HP_W-1:0]  p2_health,
    output logic [1:0]       p1_rounds,
    output logic [1:0]       p2_rounds,
    output logic [1:0]       state,
    output logic [1:0]       winner,
    output logic             tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RG_W  = (REGEN_TICKS > 0) ? $clog2(REGEN_TICKS + 1) : 1;
    localparam int GAP_W = POS_W + 1;

    // state doubles as the debug view of the FSM
    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_FIGHT      = 2'd1,
        S_ROUND_END  = 2'd2,
        S_MATCH_OVER = 2'd3
    } state_t;

    state_t           st_q;
    logic [CNT_W-1:0] tick_cnt;
    logic [RG_W-1:0]  p1_rg, p2_rg;

    // FIGHT-step results, only committed on a tick while fighting
    logic [POS_W-1:0] p1_mv, p2_mv, p1_pos_n, p2_pos_n;
    logic [GAP_W-1:0] gap;
    logic             gap_zero, kick_ok, clash, ko1, ko2;
    logic [RG_W-1:0]  p1_rg_n, p2_rg_n;
    logic [HP_W-1:0]  p1_hp_r, p2_hp_r, p1_hp_n, p2_hp_n;
    logic [1:0]       p1_dmg, p2_dmg;
    logic             win_done;

    assign state = st_q;
    assign tick  = (tick_cnt == CNT_W'(TICK_DIV - 1));

    // one step toward/away from the centre, clamped to the half-arena
    function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                  input logic fwd, input logic back);
        step_pos = pos;
        if (fwd && !back && pos != POS_W'(ARENA_LEN - 1))
            step_pos = pos + 1'b1;
        else if (back && !fwd && pos != '0)
            step_pos = pos - 1'b1;
    endfunction

    // returns {next regen count, health after regen}
    function automatic logic [RG_W+HP_W-1:0] regen(input logic idle,
                                                   input logic [RG_W-1:0] cnt,
                                                   input logic [HP_W-1:0] hp);
        logic [RG_W-1:0] c;
        logic [HP_W-1:0] h;
        c = '0;
        h = hp;
        if (idle) begin
            if (cnt == RG_W'(REGEN_TICKS - 1)) begin
                if (hp < HP_W'(HP_MAX))
                    h = hp + 1'b1;
            end else begin
                c = cnt + 1'b1;
            end
        end
        regen = {c, h};
    endfunction

    function automatic logic [HP_W-1:0] hit(input logic [HP_W-1:0] hp, input logic [1:0] dmg);
        hit = (hp > HP_W'(dmg)) ? hp - HP_W'(dmg) : '0;
    endfunction

    // resolve one FIGHT tick: move, gap, regen, attacks, clash, knockout
    always_comb begin
        p1_mv    = step_pos(p1_pos, p1_fwd, p1_back);
        p2_mv    = step_pos(p2_pos, p2_fwd, p2_back);
        gap      = (GAP_W'(ARENA_LEN - 1) - {1'b0, p1_mv}) + (GAP_W'(ARENA_LEN - 1) - {1'b0, p2_mv});
        gap_zero = (gap == '0);
        kick_ok  = (gap <= GAP_W'(KICK_RANGE));
        {p1_rg_n, p1_hp_r} = regen(p1_wait & ~(p1_kick | p1_punch | p1_jump | p1_fwd | p1_back),
                                   p1_rg, p1_health);
        {p2_rg_n, p2_hp_r} = regen(p2_wait & ~(p2_kick | p2_punch | p2_jump | p2_fwd | p2_back),
                                   p2_rg, p2_health);
        // bit 1 = punch landed (2 HP), bit 0 = kick landed (1 HP)
        p2_dmg   = {p1_punch & ~p2_punch & ~p2_jump & gap_zero,
                    p1_kick & ~p2_kick & ~p2_jump & ~p2_punch & kick_ok};
        p1_dmg   = {p2_punch & ~p1_punch & ~p1_jump & gap_zero,
                    p2_kick & ~p1_kick & ~p1_jump & ~p1_punch & kick_ok};
        p1_hp_n  = hit(p1_hp_r, p1_dmg);
        p2_hp_n  = hit(p2_hp_r, p2_dmg);
        clash    = gap_zero & ((p1_punch & p2_punch) | (p1_kick & p2_kick));
        p1_pos_n = (clash && p1_mv != '0) ? p1_mv - 1'b1 : p1_mv;
        p2_pos_n = (clash && p2_mv != '0) ? p2_mv - 1'b1 : p2_mv;
        ko1      = (p1_hp_n == '0);
        ko2      = (p2_hp_n == '0);
        win_done = (winner == 2'd1 && p1_rounds == 2'(ROUND_WIN)) ||
                   (winner == 2'd2 && p2_rounds == 2'(ROUND_WIN));
    end

    // free-running game tick divider
    always_ff @(posedge CLK) begin
        if (RST || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + 1'b1;
    end

    // round/match FSM with all game state, advanced once per tick
    always_ff @(posedge CLK) begin
        if (RST) begin
            st_q      <= S_IDLE;
            p1_pos    <= '0;
            p2_pos    <= '0;
            p1_health <= HP_W'(HP_MAX);
            p2_health <= HP_W'(HP_MAX);
            p1_rounds <= '0;
            p2_rounds <= '0;
            winner    <= '0;
            p1_rg     <= '0;
            p2_rg     <= '0;
        end else if (tick) begin
            case (st_q)
                S_IDLE: begin
                    if (start)
                        st_q <= S_FIGHT;
                end
                S_FIGHT: begin
                    p1_pos    <= p1_pos_n;
                    p2_pos    <= p2_pos_n;
                    p1_health <= p1_hp_n;
                    p2_health <= p2_hp_n;
                    p1_rg     <= p1_rg_n;
                    p2_rg     <= p2_rg_n;
                    if (ko1 || ko2) begin
                        st_q   <= S_ROUND_END;
                        winner <= {ko1, ko2};
                        if (ko2 && !ko1)
                            p1_rounds <= p1_rounds + 1'b1;
                        if (ko1 && !ko2)
                            p2_rounds <= p2_rounds + 1'b1;
                    end
                end
                S_ROUND_END: begin
                    if (win_done) begin
                        st_q <= S_MATCH_OVER;
                    end else begin
                        st_q      <= S_FIGHT;
                        p1_pos    <= '0;
                        p2_pos    <= '0;
                        p1_health <= HP_W'(HP_MAX);
                        p2_health <= HP_W'(HP_MAX);
                        p1_rg     <= '0;
                        p2_rg     <= '0;
                    end
                end
                S_MATCH_OVER: begin
                    if (start) begin
                        st_q      <= S_FIGHT;
                        p1_pos    <= '0;
                        p2_pos    <= '0;
                        p1_health <= HP_W'(HP_MAX);
                        p2_health <= HP_W'(HP_MAX);
                        p1_rounds <= '0;
                        p2_rounds <= '0;
                        winner    <= '0;
                        p1_rg     <= '0;
                        p2_rg     <= '0;
                    end
                end
                default: st_q <= S_IDLE;
            endcase
        end
    end

endmodule
